// File: rtl/voice_allocator_if.sv
// Event and voice-output bundle between the MIDI event decoder, the voice
// allocator and the oscillator bank.
//   master : event source (drives events, observes voice state)
//   slave  : allocator (accepts events, drives voice state)
interface voice_allocator_if #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 7
);
  logic                        evt_valid;
  logic                        evt_ready;
  logic [KEY_W-1:0]            evt_key;
  logic                        evt_on;
  logic [NUM_VOICES*KEY_W-1:0] voice_keys;
  logic [NUM_VOICES-1:0]       voice_active;
  logic                        drop_pulse;

  modport master (
    output evt_valid, evt_key, evt_on,
    input  evt_ready, voice_keys, voice_active, drop_pulse
  );

  modport slave (
    input  evt_valid, evt_key, evt_on,
    output evt_ready, voice_keys, voice_active, drop_pulse
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphony scheduler: assigns note-on events to free oscillator voices and
// releases them on note-off. One event is processed at a time: IDLE accepts,
// SCAN walks the voices one per cycle, COMMIT applies the update.
// Optional build macro VOICE_STEAL_EN: when defined, a note-on with every
// voice busy steals the oldest voice; when undefined the note is dropped and
// drop_pulse is raised for the COMMIT cycle (per-voice ages are only kept in
// the stealing build, since nothing else reads them).
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 7,
  parameter int AGE_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  voice_allocator_if.slave bus
);

  localparam int              IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
`ifdef VOICE_STEAL_EN
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched event and scan results
  logic [KEY_W-1:0] r_evt_key;
  logic             r_evt_on;
  logic [IDX_W-1:0] r_idx;
  logic             r_match_found;
  logic [IDX_W-1:0] r_match_idx;
  logic             r_free_found;
  logic [IDX_W-1:0] r_free_idx;
`ifdef VOICE_STEAL_EN
  logic             r_old_found;
  logic [IDX_W-1:0] r_old_idx;
  logic [AGE_W-1:0] r_old_age;
`endif

  // Flattened view of per-voice state for scanning and output
  logic [NUM_VOICES*KEY_W-1:0] w_keys_flat;
  logic [NUM_VOICES-1:0]       w_active;
`ifdef VOICE_STEAL_EN
  logic [NUM_VOICES*AGE_W-1:0] w_ages_flat;
  logic [AGE_W-1:0]            w_cur_age;
`endif

  logic             w_accept;
  logic [KEY_W-1:0] w_cur_key;
  logic             w_cur_active;

  // COMMIT decisions
  logic             w_write;
  logic             w_clear;
  logic             w_drop;
  logic [IDX_W-1:0] w_target;

  assign w_accept = bus.evt_valid && (r_state == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: one accept, NUM_VOICES scan cycles, one commit cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_SCAN;
      S_SCAN:   if (r_idx == LAST_IDX) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Select the voice currently under examination
  always_comb begin
    w_cur_key    = '0;
    w_cur_active = 1'b0;
`ifdef VOICE_STEAL_EN
    w_cur_age    = '0;
`endif
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_key    = w_keys_flat[i*KEY_W +: KEY_W];
        w_cur_active = w_active[i];
`ifdef VOICE_STEAL_EN
        w_cur_age    = w_ages_flat[i*AGE_W +: AGE_W];
`endif
      end
    end
  end

  // Latch the accepted event and accumulate match/free/oldest while scanning
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_key     <= '0;
      r_evt_on      <= 1'b0;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
`ifdef VOICE_STEAL_EN
      r_old_found   <= 1'b0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
`endif
    end else if (w_accept) begin
      r_evt_key     <= bus.evt_key;
      r_evt_on      <= bus.evt_on;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_free_found  <= 1'b0;
`ifdef VOICE_STEAL_EN
      r_old_found   <= 1'b0;
`endif
    end else if (r_state == S_SCAN) begin
      if (!r_match_found && w_cur_active && (w_cur_key == r_evt_key)) begin
        r_match_found <= 1'b1;
        r_match_idx   <= r_idx;
      end
      if (!r_free_found && !w_cur_active) begin
        r_free_found <= 1'b1;
        r_free_idx   <= r_idx;
      end
`ifdef VOICE_STEAL_EN
      // Strictly-greater keeps the lowest index on equal ages
      if (w_cur_active && (!r_old_found || (w_cur_age > r_old_age))) begin
        r_old_found <= 1'b1;
        r_old_idx   <= r_idx;
        r_old_age   <= w_cur_age;
      end
`endif
      if (r_idx != LAST_IDX) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Decide the single voice update applied in COMMIT; key 0 never changes state
  always_comb begin
    w_write  = 1'b0;
    w_clear  = 1'b0;
    w_drop   = 1'b0;
    w_target = r_free_idx;
    if ((r_state == S_COMMIT) && (r_evt_key != '0)) begin
      if (r_evt_on) begin
        if (!r_match_found) begin
          if (r_free_found) begin
            w_write  = 1'b1;
            w_target = r_free_idx;
          end else begin
`ifdef VOICE_STEAL_EN
            w_write  = r_old_found;
            w_target = r_old_idx;
`else
            w_drop   = 1'b1;
`endif
          end
        end
      end else if (r_match_found) begin
        w_clear  = 1'b1;
        w_target = r_match_idx;
      end
    end
  end

  // Per-voice key/active (and age) registers
  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic [KEY_W-1:0] r_key;
      logic             r_act;
      logic             w_sel;

      assign w_sel = (w_target == IDX_W'(gi));

      // Load on allocation/steal, clear on release
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_key <= '0;
          r_act <= 1'b0;
        end else if (w_write && w_sel) begin
          r_key <= r_evt_key;
          r_act <= 1'b1;
        end else if (w_clear && w_sel) begin
          r_key <= '0;
          r_act <= 1'b0;
        end
      end

`ifdef VOICE_STEAL_EN
      logic [AGE_W-1:0] r_age;

      // Age counts allocations made to other voices since this one was loaded
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_age <= '0;
        end else if ((w_write || w_clear) && w_sel) begin
          r_age <= '0;
        end else if (w_write && r_act && (r_age != AGE_MAX)) begin
          r_age <= r_age + 1'b1;
        end
      end

      assign w_ages_flat[gi*AGE_W +: AGE_W] = r_age;
`endif

      assign w_keys_flat[gi*KEY_W +: KEY_W] = r_key;
      assign w_active[gi]                   = r_act;
    end
  endgenerate

  assign bus.evt_ready    = (r_state == S_IDLE);
  assign bus.voice_keys   = w_keys_flat;
  assign bus.voice_active = w_active;
  assign bus.drop_pulse   = w_drop;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: the driver runs each event through a
// reference model (earliest-allocated voice is oldest, ages saturate) and
// queues the expected outputs; the monitor checks each completed event.
module tb_voice_allocator;

  localparam int NV      = 4;
  localparam int KW      = 7;
  localparam int AW      = 4;
  localparam int LAT     = NV + 1;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  voice_allocator_if #(.NUM_VOICES(NV), .KEY_W(KW)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .AGE_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  int m_key   [NV];
  bit m_act   [NV];
  int m_stamp [NV];
  int m_cnt;

  typedef struct {
    logic [NV*KW-1:0] keys;
    logic [NV-1:0]    act;
    bit               drop;
    int               key;
    bit               on;
  } exp_t;

  exp_t sb_q[$];

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_key[v] = 0; m_act[v] = 1'b0; m_stamp[v] = 0;
    end
    m_cnt = 0;
  endtask

  function automatic int m_age(input int v);
    int a;
    a = m_cnt - m_stamp[v] - 1;
    return (a > AGE_MAX) ? AGE_MAX : a;
  endfunction

  task automatic m_alloc(input int v, input int key);
    m_key[v] = key; m_act[v] = 1'b1; m_stamp[v] = m_cnt; m_cnt++;
  endtask

  task automatic model_event(input int key, input bit on, output bit drop);
    int hit, free;
    drop = 1'b0;
    if (key == 0) return;
    hit = -1;
    for (int v = NV - 1; v >= 0; v--) if (m_act[v] && m_key[v] == key) hit = v;
    if (on) begin
      if (hit >= 0) return;
      free = -1;
      for (int v = NV - 1; v >= 0; v--) if (!m_act[v]) free = v;
      if (free >= 0) begin
        m_alloc(free, key);
      end else begin
`ifdef VOICE_STEAL_EN
        int old, best;
        old = 0; best = -1;
        for (int v = 0; v < NV; v++) if (m_age(v) > best) begin best = m_age(v); old = v; end
        m_alloc(old, key);
`else
        drop = 1'b1;
`endif
      end
    end else if (hit >= 0) begin
      m_key[hit] = 0; m_act[hit] = 1'b0;
    end
  endtask

  function automatic logic [NV*KW-1:0] m_pack_keys();
    logic [NV*KW-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v*KW +: KW] = KW'(m_key[v]);
    return r;
  endfunction

  function automatic logic [NV-1:0] m_pack_act();
    logic [NV-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v] = m_act[v];
    return r;
  endfunction

  // ---------------- monitor ----------------
  bit               mon_en   = 1'b1;
  bit               mon_busy = 1'b0;
  int               low_cnt, drop_cnt, txn_no;
  bit               stable;
  logic [NV*KW-1:0] snap_keys;
  logic [NV-1:0]    snap_act;

  initial begin
    txn_no = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mon_busy = 1'b0;
        continue;
      end
      if (!mon_busy) begin
        if (!bus.evt_ready) begin
          mon_busy = 1'b1;
          low_cnt  = 1;
          stable   = (bus.voice_keys === snap_keys) && (bus.voice_active === snap_act);
          drop_cnt = bus.drop_pulse ? 1 : 0;
        end else begin
          snap_keys = bus.voice_keys;
          snap_act  = bus.voice_active;
        end
      end else if (!bus.evt_ready) begin
        low_cnt++;
        if ((bus.voice_keys !== snap_keys) || (bus.voice_active !== snap_act)) stable = 1'b0;
        if (bus.drop_pulse) drop_cnt++;
      end else begin
        mon_busy = 1'b0;
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          txn_no++;
          $display("txn %0d key=%0d on=%0d keys=%h active=%b drop=%0d lat=%0d",
                   txn_no, e.key, e.on, bus.voice_keys, bus.voice_active, drop_cnt, low_cnt);
          check("voice_keys", bus.voice_keys, e.keys);
          check("voice_active", bus.voice_active, e.act);
          check("drop_pulse_cycles", drop_cnt, e.drop ? 1 : 0);
          check("busy_cycles", low_cnt, LAT);
          check("outputs_held_until_commit", stable, 1);
        end
        snap_keys = bus.voice_keys;
        snap_act  = bus.voice_active;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int key, input bit on);
    int   guard;
    bit   d;
    exp_t e;
    @(negedge clk);
    guard = 0;
    while (!bus.evt_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        check("ready_timeout", 0, 1);
        return;
      end
    end
    model_event(key, on, d);
    e.keys = m_pack_keys(); e.act = m_pack_act(); e.drop = d; e.key = key; e.on = on;
    if (mon_en) sb_q.push_back(e);
    bus.evt_key   = KW'(key);
    bus.evt_on    = on;
    bus.evt_valid = 1'b1;
    @(negedge clk);
    guard = 0;
    // Junk on the event inputs while busy must be ignored
    while (!bus.evt_ready && guard < 50) begin
      bus.evt_valid = 1'($urandom_range(0, 1));
      bus.evt_key   = KW'($urandom_range(0, 127));
      bus.evt_on    = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
    end
    bus.evt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(bus.evt_ready && !mon_busy && sb_q.size() == 0)) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        check("idle_timeout", 0, 1);
        return;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [NV*KW-1:0] keys4(input int k3, input int k2, input int k1, input int k0);
    logic [NV*KW-1:0] r;
    r = '0;
    r[0*KW +: KW] = KW'(k0);
    r[1*KW +: KW] = KW'(k1);
    r[2*KW +: KW] = KW'(k2);
    r[3*KW +: KW] = KW'(k3);
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.evt_valid = 1'b0;
    bus.evt_key   = '0;
    bus.evt_on    = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_keys", bus.voice_keys, 0);
    check("reset_active", bus.voice_active, 0);
    check("reset_ready", bus.evt_ready, 1);
    check("reset_drop", bus.drop_pulse, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed sequence
    send(49, 1); wait_idle();
    check("first_note_keys", bus.voice_keys, keys4(0, 0, 0, 49));
    check("first_note_active", bus.voice_active, 4'b0001);
    send(40, 1); send(44, 1); send(47, 1); wait_idle();
    check("fill_keys", bus.voice_keys, keys4(47, 44, 40, 49));
    check("fill_active", bus.voice_active, 4'b1111);
    send(49, 1); send(70, 0); send(0, 1); send(0, 0); wait_idle();
    check("no_change_keys", bus.voice_keys, keys4(47, 44, 40, 49));
    send(60, 1); wait_idle();
`ifdef VOICE_STEAL_EN
    check("full_note_on_keys", bus.voice_keys, keys4(47, 44, 40, 60));
`else
    check("full_note_on_keys", bus.voice_keys, keys4(47, 44, 40, 49));
`endif
    send(44, 0); wait_idle();
    check("note_off_active", bus.voice_active, 4'b1011);
    send(52, 1); wait_idle();
    check("refill_voice2", bus.voice_keys[2*KW +: KW], 52);
    check("refill_active", bus.voice_active, 4'b1111);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      int  k;
      bit  o;
      k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      o = ($urandom_range(0, 99) < 60);
      send(k, o);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    send(21, 1);
    wait_idle();

    // Reset while a note-on is being scanned
    mon_en = 1'b0;
    @(negedge clk);
    bus.evt_key   = KW'(33);
    bus.evt_on    = 1'b1;
    bus.evt_valid = 1'b1;
    @(negedge clk);
    bus.evt_valid = 1'b0;
    check("scan_in_progress", bus.evt_ready, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_keys", bus.voice_keys, 0);
    check("async_reset_active", bus.voice_active, 0);
    check("async_reset_drop", bus.drop_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", bus.evt_ready, 1);
    repeat (LAT + 2) @(negedge clk);
    check("pending_not_committed_keys", bus.voice_keys, 0);
    check("pending_not_committed_active", bus.voice_active, 0);
    model_reset();
    mon_en = 1'b1;
    @(negedge clk);
    send(49, 1); wait_idle();
    check("post_reset_note", bus.voice_keys, keys4(0, 0, 0, 49));

    check("sb_leftover", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphony scheduler sitting between the keyboard/MIDI event decoder and a bank of NUM_VOICES oscillator instances. It accepts serialized note-on/note-off events and assigns each sounding key to a free oscillator voice, releasing voices on note-off. Each voice output drives one oscillator key input; key code 0 means silent, since the oscillator maps out-of-table keys to zero frequency.

Parameters:
NUM_VOICES, 4, number of oscillator voices managed (2..16)
KEY_W, 7, width of a key code; must match the oscillator key input width
AGE_W, 4, width of per-voice age counter; must satisfy 2^AGE_W >= NUM_VOICES

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
evt_valid  input  1  event present on evt_key/evt_on
evt_ready  output  1  allocator can accept an event this cycle
evt_key  input  KEY_W  key code of event; 0 is illegal and ignored
evt_on  input  1  1 = note-on, 0 = note-off
voice_keys  output  NUM_VOICES*KEY_W  per-voice key, voice i at bits [i*KEY_W +: KEY_W]; 0 = silent
voice_active  output  NUM_VOICES  bit i set while voice i is sounding
drop_pulse  output  1  one-cycle pulse when a note-on is discarded

Behaviour:
- Reset, async on rst_n low: voice_keys=0, voice_active=0, all ages=0, drop_pulse=0, FSM=IDLE, evt_ready=1.
- Handshake: event accepted on the rising edge where evt_valid && evt_ready. The event is latched internally. evt_ready is high only in IDLE.
- Events with evt_key==0 are accepted and discarded, with no state change and no drop_pulse.
- FSM states:
  - IDLE: on accept, go to SCAN with index=0.
  - SCAN: examine one voice per cycle, index 0..NUM_VOICES-1. Track: first voice whose key equals evt_key and is active (match); lowest-index inactive voice (free); active voice with the largest age, lowest index winning ties (oldest). After the last index, go to COMMIT.
  - COMMIT: apply the update for one cycle, then return to IDLE.
- COMMIT rules, note-on:
  - match found: no voice change (retrigger ignored).
  - else free found: voice_keys[free]=evt_key, active set, age[free]=0; every other active voice's age increments, saturating at 2^AGE_W-1.
  - else (all busy): steal or drop, per Optional Feature.
- COMMIT rules, note-off:
  - match found: voice_keys[match]=0, active cleared, age cleared.
  - no match: no change.
- Latency: accept edge to output update is NUM_VOICES+1 cycles. Outputs change only in COMMIT. Event throughput is 1 per NUM_VOICES+2 cycles.
- voice_keys and voice_active are registered and glitch-free. The oscillator's own key-lookup register adds one further cycle downstream.
- Invariant: no two active voices hold the same key.
- Reset mid-SCAN or mid-COMMIT: the in-flight event is lost, and all outputs clear immediately.
- evt_valid deasserting while evt_ready is low is legal. Only the accepted event is processed.

Optional Feature:
Macro VOICE_STEAL_EN.
- Defined: a note-on with all voices busy steals the oldest voice. voice_keys[oldest]=evt_key, age reset to 0, other ages increment, drop_pulse stays 0.
- Undefined: such a note-on is discarded with no voice change, and drop_pulse=1 for the COMMIT cycle. The age logic may still be present, but it affects nothing.

Test Plan:
- Reset, then note-on key 49 -> voice_keys[0]=49 and voice_active=4'b0001 exactly 5 cycles after accept (NUM_VOICES=4). evt_ready is low for cycles 1..5.
- Note-on 40, 44, 47 after 49 -> voices 0..3 = 49, 40, 44, 47 and voice_active=4'b1111. A note-off 44 then leaves voice 2 = 0 and active=4'b1011.
- Note-on 60 with voices 0..3 = 49, 40, 44, 47 all busy, VOICE_STEAL_EN defined -> voice 0 (oldest) becomes 60 and drop_pulse stays 0. With the macro undefined -> no change and drop_pulse high for 1 cycle.
- Note-on 49 while 49 is already sounding -> no output change. Note-off 70 (not sounding) -> no change. An event with evt_key=0 -> no change.
- After a free slot (voice 2) opens, note-on 52 -> lands in voice 2, the lowest free index, not in a stolen voice.
- rst_n pulsed low during SCAN of a note-on -> outputs 0 immediately, evt_ready=1 the cycle after release, and the pending note is never committed.
